// File: rtl/sha256_compress.sv
// Sequential SHA-256 compression engine: one round per clock over a rolling
// 16-word message schedule, followed by a single chaining-add cycle.
module sha256_compress (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_var  [8];   // working variables a..h
  logic [31:0]   r_hold [8];
  logic [31:0]   r_win  [16];
  logic [5:0]    r_t;
  logic          r_done;
  logic [255:0]  r_digest;

  logic [31:0]   w_k;
  logic [31:0]   w_t1;
  logic [31:0]   w_t2;
  logic [31:0]   w_wnew;

  assign w_k    = K[r_t];
  assign w_t1   = r_var[7] + big_sig1(r_var[4])
                + ((r_var[4] & r_var[5]) ^ (~r_var[4] & r_var[6]))
                + w_k + r_win[0];
  assign w_t2   = big_sig0(r_var[0])
                + ((r_var[0] & r_var[1]) ^ (r_var[0] & r_var[2]) ^ (r_var[1] & r_var[2]));
  assign w_wnew = sml_sig1(r_win[14]) + r_win[9] + sml_sig0(r_win[1]) + r_win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = ROUND;
      ROUND:   if (r_t == 6'd63) w_next = FINAL;
      FINAL:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_var[i]  <= '0;
        r_hold[i] <= '0;
      end
      for (int unsigned i = 0; i < 16; i++) r_win[i] <= '0;
      r_t      <= '0;
      r_done   <= 1'b0;
      r_digest <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < 8; i++) begin
              r_var[i]  <= hash_in[255 - 32*i -: 32];
              r_hold[i] <= hash_in[255 - 32*i -: 32];
            end
            for (int unsigned i = 0; i < 16; i++) r_win[i] <= block_in[511 - 32*i -: 32];
            r_t <= '0;
          end
        end
        ROUND: begin
          r_var[0] <= w_t1 + w_t2;
          r_var[1] <= r_var[0];
          r_var[2] <= r_var[1];
          r_var[3] <= r_var[2];
          r_var[4] <= r_var[3] + w_t1;
          r_var[5] <= r_var[4];
          r_var[6] <= r_var[5];
          r_var[7] <= r_var[6];
          // Window words produced in the last 16 rounds are never consumed.
          for (int unsigned i = 0; i < 15; i++) r_win[i] <= r_win[i + 1];
          r_win[15] <= w_wnew;
          r_t       <= r_t + 6'd1;
        end
        FINAL: begin
          for (int unsigned i = 0; i < 8; i++)
            r_digest[255 - 32*i -: 32] <= r_hold[i] + r_var[i];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready  = (r_state == IDLE);
  assign done   = r_done;
  assign digest = r_digest;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: block-level SHA-256 reference model
// plus known-answer vectors, directed timing/reset scenarios and random traffic.
module tb_sha256_compress;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H_INIT   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] DIG_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] BLK_EMP  = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_EMP  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] BLK_TW1  = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                       32'h80000000, 32'h0};
  localparam logic [511:0] BLK_TW2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] hash_in = '0;
  logic         ready;
  logic         done;
  logic [255:0] digest;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  int           m_cnt = 0;
  logic [255:0] m_res = '0;
  logic [255:0] m_digest = '0;
  logic         m_done = 1'b0;

  sha256_compress dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .ready    (ready),
    .done     (done),
    .digest   (digest)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 block compression: full 64-word schedule, then rounds.
  function automatic logic [255:0] sha_ref(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Cycle-level expectation: a block occupies 65 edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_done = 1'b0;
      m_digest = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (start === 1'b1) begin
          m_res = sha_ref(hash_in, block_in);
          m_cnt = 1;
        end
      end else if (m_cnt == 65) begin
        m_digest = m_res;
        m_done = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", {255'h0, ready}, {255'h0, (m_cnt == 0)});
      check("done", {255'h0, done}, {255'h0, m_done});
      check("digest", digest, m_digest);
    end
  end

  task automatic randomize_inputs();
    for (int j = 0; j < 16; j++) block_in[32*j +: 32] = $urandom;
    for (int j = 0; j < 8; j++) hash_in[32*j +: 32] = $urandom;
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input logic [511:0] blk, input logic [255:0] h);
    block_in = blk;
    hash_in  = h;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    randomize_inputs();
  endtask

  task automatic wait_done(input int busy1, input int busy2, output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (n == busy1 || n == busy2) begin
        randomize_inputs();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_200");
    end
  endtask

  initial begin
    int n;
    int seen;
    logic [255:0] chain_h;

    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("model_abc", sha_ref(H_INIT, BLK_ABC), DIG_ABC);
    check("model_empty", sha_ref(H_INIT, BLK_EMP), DIG_EMP);
    repeat (3) @(negedge clk);
    check("reset_digest", digest, '0);
    check("reset_ready", {255'h0, ready}, 256'h1);

    // Release and start on the very next edge; busy-start pulses at rounds 10 and 40.
    rst_n = 1'b1;
    launch(BLK_ABC, H_INIT);
    wait_done(10, 40, n);
    check("abc_latency", n, 65);
    check("abc_digest", digest, DIG_ABC);

    @(negedge clk);
    launch(BLK_EMP, H_INIT);
    wait_done(-1, -1, n);
    check("empty_digest", digest, DIG_EMP);

    @(negedge clk);
    launch(BLK_TW1, H_INIT);
    wait_done(-1, -1, n);
    chain_h = m_digest;
    launch(BLK_TW2, chain_h);
    wait_done(-1, -1, n);
    check("chain_gap", n + 1, 66);
    check("chain_digest", digest, DIG_TWO);

    // Asynchronous reset between edges takes effect immediately.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", {255'h0, ready}, 256'h1);
    check("async_done", {255'h0, done}, 256'h0);
    check("async_digest", digest, '0);
    #1 rst_n = 1'b1;
    block_in = BLK_ABC;
    hash_in  = H_INIT;
    start    = 1'b1;
    @(posedge clk);
    #1 check("rst_accept", {255'h0, ready}, 256'h0);
    @(negedge clk);
    start = 1'b0;
    randomize_inputs();
    wait_done(-1, -1, n);
    check("rst_abc_digest", digest, DIG_ABC);

    // Abort mid-block.
    @(negedge clk);
    launch(BLK_ABC, H_INIT);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_digest", digest, '0);
    launch(BLK_ABC, H_INIT);
    wait_done(-1, -1, n);
    check("midrst_abc_digest", digest, DIG_ABC);

    // Random traffic, including starts while busy and in the done cycle.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      randomize_inputs();
      start = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

Sequential SHA-256 compression engine: accepts one 512-bit padded message block plus a 256-bit chaining value, runs the 64 compression rounds one per clock, and returns the updated 256-bit hash. It is the consumer of the T2 datapath (`func_t2`, T2 = Σ0(a) + Maj(a,b,c)). It computes T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t] alongside, and owns the working-variable registers a..h, the round counter, the K constant ROM and the rolling message schedule. Multi-block messages are hashed by feeding each digest back as the next `hash_in`.

## Interface
- No parameters. Word size is fixed at 32, rounds at 64, block size at 512.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when `ready`=1.
- block_in  input  512  padded message block. W[0] = [511:480], W[15] = [31:0].
- hash_in  input  256  chaining value. H0 = [255:224], H7 = [31:0]. Sampled with `start`.
- ready  output  1  engine idle and able to accept `start`.
- done  output  1  one-cycle pulse: `digest` has just been updated.
- digest  output  256  result, same word order as `hash_in`. Held until the next completion.

## Operation
- States:
  - IDLE: ready=1.
  - ROUND: t = 0..63.
  - FINAL: the chaining add.
- IDLE -> ROUND on start=1. Same edge:
  - a..h <= hash_in.
  - Hold register <= hash_in.
  - Schedule window win[0..15] <= W[0..15].
  - t <= 0.
- ROUND, each edge:
  - W[t] = win[0].
  - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - win shifts down one place. win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0].
  - t <= t+1.
  - At t=63: go to FINAL.
  - The window keeps shifting for t>=48; the words generated there are don't-care.
- FINAL, one edge:
  - digest[i] <= hold[i] + var[i] for each of the 8 words.
  - done <= 1.
  - Go to IDLE.
- Arithmetic: all additions are 32-bit modulo 2^32, carries discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - K[0..63] are the FIPS 180-4 constants, combinational ROM indexed by t (6-bit).
- `start` while ready=0 is ignored. Nothing is queued and in-flight state is unaffected.
- `block_in` and `hash_in` need only be valid in the `start` cycle; the engine captures both.

## Timing
- Reset (async assert, any state):
  - state=IDLE, ready=1, done=0, digest=0.
  - a..h, hold, win, t all cleared to 0.
- Reset mid-operation aborts the block. No `done` is produced and `digest` reads 0.
- Release is synchronous to clk. The first `start` is accepted on the first edge after rst_n rises.
- Start accepted on edge E0:
  - ready=0 from E0.
  - Rounds execute on edges E1..E64.
  - FINAL on E65: digest updates and done=1 for the cycle after E65.
  - ready=1 again after E65.
  - Latency: 65 clocks from the accepting edge to `digest` valid.
- `done` and `ready` are both high in the cycle after E65. A `start` in that cycle is accepted on E66, giving back-to-back blocks every 66 clocks. `done` still falls after E66.
- `digest` changes only at FINAL or reset. It is stable while ready=0.

## Test plan
- Reset: assert rst_n=0 mid-clock with no edge -> ready=1, done=0, digest=0 immediately. Release, then start on the next edge -> accepted.
- "abc":
  - Stimulus: block_in = 61626380 followed by 14 words of 0 and 00000018; hash_in = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - Response: done exactly 65 clocks after the start edge; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: block_in = 80000000 followed by 15 zero words, standard H0 -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block chain: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits, padded to two blocks).
  - Start block 2 in the `done` cycle of block 1, with hash_in = that digest.
  - Response: second done arrives 66 clocks after the first; digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Busy-start: during "abc", pulse start with a different block at rounds 10 and 40 -> ignored; the "abc" digest and timing are unchanged.
- Mid-op reset: pulse rst_n low at round 30 of "abc" -> no done, digest=0. Restarting "abc" afterwards yields the correct digest.
